// File: rtl/factory_test_pkg.sv
// Shared types and helpers for the factory-test pattern engines.
package factory_test_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fsm_state_e;

  // Feedback taps for x^8+x^6+x^5+x^4+1 in shift-left Fibonacci form: bits 7,5,4,3.
  localparam logic [7:0] LFSR_TAPS    = 8'b1011_1000;
  localparam logic [7:0] DEFAULT_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_next(input logic [7:0] cur);
    return {cur[6:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/factory_lfsr8.sv
// 8-bit pattern LFSR with synchronous load and advance; load has priority.
module factory_lfsr8
  import factory_test_pkg::*;
#(
  parameter logic [7:0] SEED = DEFAULT_SEED
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  output logic [7:0] value
);

  logic [7:0] value_r;

  // Pattern register: reload to seed or step the polynomial.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_r <= SEED;
    end else if (load) begin
      value_r <= SEED;
    end else if (advance) begin
      value_r <= lfsr_next(value_r);
    end
  end

  assign value = value_r;

endmodule

// File: rtl/factory_loopback_checker.sv
// PRBS loopback engine: drives an LFSR pattern out, compares the looped-back
// bytes against a delayed copy and reports busy/done/pass/error count.
module factory_loopback_checker
  import factory_test_pkg::*;
#(
  parameter int unsigned LENGTH  = 255,
  parameter logic [7:0]  SEED    = DEFAULT_SEED,
  parameter int unsigned LATENCY = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic       start,
  input  logic [7:0] rx_data,
  output logic [7:0] tx_data,
  output logic [7:0] tx_oe,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] err_count
);

  localparam logic [7:0]  SEED_EFF   = (SEED == 8'h00) ? 8'h01 : SEED;
  localparam logic [15:0] LAST_WORD  = 16'(LENGTH - 1);
  localparam logic [15:0] LAST_DRAIN = 16'(LATENCY - 1);

  fsm_state_e  state_r, state_s;
  logic [15:0] count_r;
  logic [7:0]  lfsr_s;
  logic        load_s, advance_s;
  logic [7:0]  tx_data_r, tx_oe_r, err_r, err_next_s;
  logic        busy_r, done_r, pass_r;
  logic [7:0]  dl_data_r  [LATENCY];
  logic        dl_valid_r [LATENCY];
  logic        mismatch_s;

  factory_lfsr8 #(.SEED(SEED_EFF)) u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_s & ena),
    .advance (advance_s & ena),
    .value   (lfsr_s)
  );

  // Next-state and run-control decode.
  always_comb begin
    state_s   = state_r;
    load_s    = 1'b0;
    advance_s = 1'b0;
    case (state_r)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_s = ST_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (count_r == LAST_WORD) begin
          state_s = ST_DRAIN;
        end else begin
          advance_s = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (count_r == LAST_DRAIN) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Compare the word leaving the delay line; the count saturates at FF.
  always_comb begin
    mismatch_s = dl_valid_r[LATENCY-1] && (dl_data_r[LATENCY-1] != rx_data);
    if (load_s) begin
      err_next_s = 8'h00;
    end else if (mismatch_s && (err_r != 8'hFF)) begin
      err_next_s = err_r + 8'd1;
    end else begin
      err_next_s = err_r;
    end
  end

  // State, counter and registered outputs; everything holds while ena is low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      count_r   <= 16'd0;
      tx_data_r <= 8'h00;
      tx_oe_r   <= 8'h00;
      err_r     <= 8'h00;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      pass_r    <= 1'b0;
    end else if (ena) begin
      state_r <= state_s;
      err_r   <= err_next_s;
      if (load_s) begin
        count_r <= 16'd0;
      end else if ((state_r == ST_RUN) && (state_s == ST_DRAIN)) begin
        count_r <= 16'd0;
      end else if ((state_r == ST_RUN) || (state_r == ST_DRAIN)) begin
        count_r <= count_r + 16'd1;
      end
      if (load_s) begin
        tx_data_r <= SEED_EFF;
      end else if (advance_s) begin
        tx_data_r <= lfsr_next(lfsr_s);
      end
      busy_r  <= (state_s == ST_RUN) || (state_s == ST_DRAIN);
      tx_oe_r <= ((state_s == ST_RUN) || (state_s == ST_DRAIN)) ? 8'hFF : 8'h00;
      done_r  <= (state_s == ST_DONE);
      pass_r  <= (state_s == ST_DONE) && (err_next_s == 8'h00);
    end
  end

  // Delay line aligning each sent word with its returning copy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LATENCY; i++) begin
        dl_data_r[i]  <= 8'h00;
        dl_valid_r[i] <= 1'b0;
      end
    end else if (ena) begin
      dl_data_r[0]  <= tx_data_r;
      dl_valid_r[0] <= (state_r == ST_RUN);
      for (int i = 1; i < LATENCY; i++) begin
        dl_data_r[i]  <= dl_data_r[i-1];
        dl_valid_r[i] <= dl_valid_r[i-1];
      end
    end
  end

  assign tx_data   = tx_data_r;
  assign tx_oe     = tx_oe_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign pass      = pass_r;
  assign err_count = err_r;

endmodule
